// File: rtl/lcd_fb_writer.sv
// Captures the 2 bpp pixel stream from the LCD controller, packs four pixels per byte
// and writes the bytes into a framebuffer through a small FIFO and a request/ack port.
module lcd_fb_writer #(
  parameter logic [12:0] FB_BASE    = 13'h0000,
  parameter int          LINE_BYTES = 40,
  parameter int          LINES      = 144,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        hs,
  input  logic        vs,
  input  logic        cpl,
  input  logic [1:0]  pixel,
  input  logic        valid,
  output logic [12:0] fb_a,
  output logic [7:0]  fb_dout,
  output logic        fb_wr,
  input  logic        fb_ack,
  output logic        frame_done,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int          PW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  X_MAX  = 8'(4 * LINE_BYTES);
  localparam logic [7:0]  Y_MAX  = 8'(LINES);
  localparam logic [12:0] LINE_W = 13'(LINE_BYTES);

  typedef enum logic {IDLE, REQ} state_t;

  logic        hs_q, vs_q, cpl_q;
  logic        armed;
  logic [7:0]  x, y;
  logic [12:0] line_base;
  logic [5:0]  shift;
  logic [1:0]  cnt;
  state_t      state;

  logic [20:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;

  logic        vs_fall, hs_fall, cpl_rise, pix_ev;
  logic        push_req, do_push, drop, pop, empty, full;
  logic [7:0]  new_byte, flush_byte, push_data;
  logic [12:0] push_addr;
  logic [20:0] head;

  // vs takes priority over hs; a pixel coinciding with either sync edge is discarded.
  assign vs_fall  = vs_q & ~vs;
  assign hs_fall  = hs_q & ~hs & ~vs_fall;
  assign cpl_rise = ~cpl_q & cpl;
  assign pix_ev   = cpl_rise & valid & armed & (x < X_MAX) & (y < Y_MAX) & ~vs_fall & ~hs_fall;

  assign new_byte = {shift, pixel};

  always_comb begin
    flush_byte = 8'h00;
    case (cnt)
      2'd1:    flush_byte = {shift[1:0], 6'b0};
      2'd2:    flush_byte = {shift[3:0], 4'b0};
      2'd3:    flush_byte = {shift, 2'b0};
      default: flush_byte = 8'h00;
    endcase
  end

  // x counts pixels already taken on this line, so x/4 is the byte being completed.
  assign push_req  = (pix_ev && cnt == 2'd3) || (hs_fall && cnt != 2'd0);
  assign push_data = hs_fall ? flush_byte : new_byte;
  assign push_addr = line_base + {5'b0, x[7:2]};

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop     = (state == REQ) && fb_ack;
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      cpl_q      <= 1'b0;
      armed      <= 1'b0;
      x          <= 8'd0;
      y          <= 8'd0;
      line_base  <= FB_BASE;
      shift      <= 6'd0;
      cnt        <= 2'd0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
    end else begin
      hs_q       <= hs;
      vs_q       <= vs;
      cpl_q      <= cpl;
      frame_done <= vs_fall;
      if (vs_fall) begin
        armed     <= en;
        x         <= 8'd0;
        y         <= 8'd0;
        line_base <= FB_BASE;
        shift     <= 6'd0;
        cnt       <= 2'd0;
      end else if (hs_fall) begin
        x         <= 8'd0;
        if (y != Y_MAX) y <= y + 8'd1;
        line_base <= line_base + LINE_W;
        shift     <= 6'd0;
        cnt       <= 2'd0;
      end else if (pix_ev) begin
        x     <= x + 8'd1;
        shift <= new_byte[5:0];
        cnt   <= cnt + 2'd1;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      fb_wr   <= 1'b0;
      fb_a    <= 13'd0;
      fb_dout <= 8'd0;
      rd_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            fb_a    <= head[20:8];
            fb_dout <= head[7:0];
            fb_wr   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (fb_ack) begin
            fb_wr  <= 1'b0;
            rd_ptr <= rd_ptr + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed bench for lcd_fb_writer: a table of single-line packing vectors plus
// hand-written sequences for overflow, reset, enable gating, latency and a full frame.
module tb_lcd_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n, en, hs, vs, cpl, valid, fb_ack, ovf_clr;
  logic [1:0]  pixel;
  logic [12:0] fb_a;
  logic [7:0]  fb_dout;
  logic        fb_wr, frame_done, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [12:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [15:0] pix;
    int          npix;
    int          nexp;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs[7];

  lcd_fb_writer #(.FB_BASE(13'h0000), .LINE_BYTES(40), .LINES(144), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .cpl(cpl), .pixel(pixel),
    .valid(valid), .fb_a(fb_a), .fb_dout(fb_dout), .fb_wr(fb_wr), .fb_ack(fb_ack),
    .frame_done(frame_done), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && fb_wr && fb_ack) wq.push_back({fb_a, fb_dout});
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [1:0] p);
    pixel = p; valid = 1'b1; cpl = 1'b1;
    tick();
    cpl = 1'b0;
    tick();
  endtask

  task automatic hs_pulse();
    hs = 1'b0; tick();
    hs = 1'b1; tick();
  endtask

  task automatic vs_pulse(output logic fd_hi, output logic fd_lo);
    vs = 1'b0; tick(); fd_hi = frame_done;
    vs = 1'b1; tick(); fd_lo = frame_done;
  endtask

  task automatic drain();
    repeat (16) tick();
  endtask

  function automatic int q_addr(input int k);
    return (wq.size() > k) ? int'(wq[k].a) : -1;
  endfunction

  function automatic int q_data(input int k);
    return (wq.size() > k) ? int'(wq[k].d) : -1;
  endfunction

  initial begin
    logic fd1, fd2;
    int   lat, bad;
    vecs[0] = '{16'h1B00, 4, 1, 8'h1B, 8'h00};
    vecs[1] = '{16'hFFF0, 6, 2, 8'hFF, 8'hF0};
    vecs[2] = '{16'h8000, 1, 1, 8'h80, 8'h00};
    vecs[3] = '{16'h6C00, 3, 1, 8'h6C, 8'h00};
    vecs[4] = '{16'hE41B, 8, 2, 8'hE4, 8'h1B};
    vecs[5] = '{16'h0000, 0, 0, 8'h00, 8'h00};
    vecs[6] = '{16'h5554, 7, 2, 8'h55, 8'h54};

    rst_n = 1'b0; en = 1'b0; hs = 1'b1; vs = 1'b1; cpl = 1'b0; valid = 1'b0;
    pixel = 2'b00; fb_ack = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check("rst_fb_wr", fb_wr, 0);
    check("rst_fb_a", fb_a, 0);
    check("rst_fb_dout", fb_dout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1; en = 1'b1; fb_ack = 1'b1;
    tick();

    // no capture before the first frame start
    wq.delete();
    for (int i = 0; i < 4; i++) send_pix(2'(i));
    hs_pulse();
    drain();
    check("no_cap_before_vs", wq.size(), 0);

    for (int v = 0; v < 7; v++) begin
      wq.delete();
      vs_pulse(fd1, fd2);
      for (int i = 0; i < vecs[v].npix; i++) send_pix(vecs[v].pix[15-2*i -: 2]);
      hs_pulse();
      drain();
      check($sformatf("vec%0d_count", v), wq.size(), vecs[v].nexp);
      if (vecs[v].nexp > 0) begin
        check($sformatf("vec%0d_a0", v), q_addr(0), 0);
        check($sformatf("vec%0d_d0", v), q_data(0), int'(vecs[v].b0));
      end
      if (vecs[v].nexp > 1) begin
        check($sformatf("vec%0d_a1", v), q_addr(1), 1);
        check($sformatf("vec%0d_d1", v), q_data(1), int'(vecs[v].b1));
      end
    end

    // second line lands at base + LINE_BYTES
    wq.delete();
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 6; i++) send_pix(2'b11);
    hs_pulse();
    send_pix(2'b00); send_pix(2'b01); send_pix(2'b10); send_pix(2'b11);
    hs_pulse();
    drain();
    check("line2_count", wq.size(), 3);
    check("line2_addr", q_addr(2), 40);
    check("line2_data", q_data(2), 8'h1B);

    // latency from the 4th cpl edge to fb_wr
    wq.delete();
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 3; i++) send_pix(2'b01);
    pixel = 2'b01; cpl = 1'b1;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) cpl = 1'b0;
      if (fb_wr && lat == 0) lat = k;
    end
    check("latency_le3", int'(lat >= 1 && lat <= 3), 1);
    drain();
    check("latency_data", q_data(0), 8'h55);

    // FIFO overflow with ack held low
    fb_ack = 1'b0;
    wq.delete();
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 16; i++) send_pix(2'(i % 4));
    check("ovf_after_4", overflow, 0);
    for (int i = 0; i < 4; i++) send_pix(2'(i % 4));
    check("ovf_after_5", overflow, 1);
    fb_ack = 1'b1;
    drain();
    check("ovf_write_count", wq.size(), 4);
    check("ovf_last_addr", q_addr(3), 3);
    check("ovf_still_set", overflow, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // drop and clear in the same cycle: set wins
    fb_ack = 1'b0;
    wq.delete();
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 19; i++) send_pix(2'(i % 4));
    pixel = 2'b11; cpl = 1'b1; ovf_clr = 1'b1;
    tick();
    cpl = 1'b0; ovf_clr = 1'b0;
    tick();
    check("ovf_set_wins", overflow, 1);
    fb_ack = 1'b1;
    drain();
    check("ovf2_write_count", wq.size(), 4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // asynchronous reset mid-line
    fb_ack = 1'b0;
    vs_pulse(fd1, fd2);
    hs_pulse();
    for (int i = 0; i < 6; i++) send_pix(2'b11);
    check("pre_rst_fb_wr", fb_wr, 1);
    check("pre_rst_fb_a", fb_a, 40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_fb_wr", fb_wr, 0);
    check("async_rst_fb_a", fb_a, 0);
    check("async_rst_fb_dout", fb_dout, 0);
    tick(); tick();
    rst_n = 1'b1; fb_ack = 1'b1;
    wq.delete();
    for (int i = 0; i < 8; i++) send_pix(2'b10);
    hs_pulse();
    for (int i = 0; i < 4; i++) send_pix(2'b10);
    drain();
    check("post_rst_no_writes", wq.size(), 0);
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 4; i++) send_pix(2'b11);
    drain();
    check("post_rst_resume_cnt", wq.size(), 1);
    check("post_rst_resume_a", q_addr(0), 0);

    // capture disabled for a whole frame
    en = 1'b0;
    wq.delete();
    vs_pulse(fd1, fd2);
    check("en0_frame_done_hi", fd1, 1);
    check("en0_frame_done_lo", fd2, 0);
    for (int i = 0; i < 8; i++) send_pix(2'b01);
    hs_pulse();
    for (int i = 0; i < 4; i++) send_pix(2'b01);
    drain();
    check("en0_no_writes", wq.size(), 0);
    en = 1'b1;
    vs_pulse(fd1, fd2);
    for (int i = 0; i < 4; i++) send_pix(2'b01);
    drain();
    check("en1_resume_cnt", wq.size(), 1);
    check("en1_resume_a", q_addr(0), 0);
    check("en1_resume_d", q_data(0), 8'h55);

    // full frame; line 0 and a 145th line carry extra pixels that must be clipped
    wq.delete();
    vs_pulse(fd1, fd2);
    for (int ln = 0; ln < 144; ln++) begin
      for (int i = 0; i < (ln == 0 ? 164 : 160); i++) send_pix(i < 160 ? 2'(i % 4) : 2'b11);
      hs_pulse();
    end
    for (int i = 0; i < 4; i++) send_pix(2'b11);
    hs_pulse();
    drain();
    check("frame_count", wq.size(), 5760);
    bad = -1;
    foreach (wq[i]) begin
      if (bad < 0 && (int'(wq[i].a) != i || wq[i].d != 8'h1B)) bad = i;
    end
    check("frame_first_bad_idx", bad, -1);
    check("frame_d0", q_data(0), 8'h1B);
    check("frame_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_fb_writer.md
LCD_FB_WRITER -- requirements
Module: lcd_fb_writer

Interface
REQ-001 Parameter FB_BASE, 13'h0000, framebuffer start byte address.
REQ-002 Parameter LINE_BYTES, 40, bytes per captured line (160 px at 2 bpp).
REQ-003 Parameter LINES, 144, lines captured per frame.
REQ-004 Parameter FIFO_DEPTH, 4, pending-write FIFO entries (power of 2).
REQ-005 clk  in  1  system clock, same 4.19 MHz clock as the LCD source.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 en  in  1  capture enable, sampled only at frame start.
REQ-008 hs  in  1  horizontal sync from PPU, active-low.
REQ-009 vs  in  1  vertical sync from PPU, active-low.
REQ-010 cpl  in  1  pixel latch from PPU; a pixel is presented on each 0->1 transition.
REQ-011 pixel  in  2  pixel data, 2 bpp.
REQ-012 valid  in  1  pixel-valid qualifier from PPU.
REQ-013 fb_a  out  13  framebuffer byte address.
REQ-014 fb_dout  out  8  packed pixel byte.
REQ-015 fb_wr  out  1  write request, held until acknowledged.
REQ-016 fb_ack  in  1  write accepted at this clock edge.
REQ-017 frame_done  out  1  one-cycle pulse at each frame start (vs falling edge).
REQ-018 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-019 ovf_clr  in  1  clears overflow.

Function
REQ-020 Edge detection: hs, vs and cpl registered once; a falling edge is prev=1/cur=0, and a rising edge is prev=0/cur=1.
REQ-021 Pixel event: cpl rising edge AND valid=1 AND armed=1 AND x<4*LINE_BYTES AND y<LINES.
- Pixels outside the x or y limits are ignored (clipped).
REQ-022 vs falling edge performs all of the following in one cycle:
- armed<=en;
- x<=0, y<=0, line_base<=FB_BASE;
- shift register and pixel count cleared;
- frame_done pulses.
REQ-023 hs falling edge (vs not falling in the same cycle) performs all of the following:
- if pixel count in [1..3], flush the partial byte padded with 2'b00 in the unused low positions;
- x<=0, y<=y+1 (saturate at LINES), line_base<=line_base+LINE_BYTES;
- shift register and pixel count cleared.
REQ-024 Packing is MSB-first: first pixel of each group in bits [7:6], fourth in [1:0].
REQ-025 On the 4th pixel event, {line_base+x/4, byte} is pushed to the FIFO in the same cycle.
REQ-026 Address arithmetic:
- incremental only, no multiplier;
- line_base is 13-bit and wraps modulo 8192;
- x is 8-bit.
REQ-027 FIFO full when a push occurs: the byte is dropped, overflow<=1, and FIFO contents are unchanged.
REQ-028 Simultaneous push and pop on a full FIFO is allowed and is not an overflow.
REQ-029 ovf_clr=1 clears overflow; if a drop happens in the same cycle, overflow stays 1 (set wins).
REQ-030 Output state machine IDLE/REQ:
- IDLE: FIFO non-empty -> load head into fb_a/fb_dout, fb_wr<=1, go to REQ;
- REQ: fb_a/fb_dout stable, fb_wr=1; on fb_ack=1 pop, fb_wr<=0, go to IDLE.
REQ-031 Minimum spacing: one idle cycle between consecutive requests (fb_wr deasserted for at least 1 cycle).
REQ-032 fb_ack while in IDLE is ignored.
REQ-033 Frame boundary: bytes already queued drain normally; a vs edge does not flush or discard the FIFO.
REQ-034 en deasserted mid-frame takes effect only at the next vs falling edge.
REQ-035 Latency: the 4th-pixel cpl edge on input leads to fb_wr=1 no later than 3 cycles later when the FIFO was empty.

Reset
REQ-036 While rst_n=0, and immediately on its assertion:
- fb_wr=0, fb_a=0, fb_dout=0, frame_done=0, overflow=0;
- FIFO empty, state IDLE, armed=0, x=0, y=0, line_base=FB_BASE;
- edge registers set to 1 for hs/vs and 0 for cpl.
REQ-037 After release, no pixel is captured until the first vs falling edge with en=1.
- A mid-frame reset discards the partial frame.

Verification
REQ-038 Full frame, en=1, fb_ack tied 1, FB_BASE=0:
- stimulus: 144 lines of 160 pixels each;
- response: 5760 writes covering addresses 0..5759 in order, overflow=0;
- response: first line of pixels 0,1,2,3,... gives byte 0x1B at address 0.
REQ-039 Line of 6 pixels (all 2'b11) then hs falling -> writes 0xFF@base and 0xF0@base+1; next line starts at base+40.
REQ-040 fb_ack held 0 while 5 bytes are pushed -> 4 queued, 5th dropped, overflow=1; release ack -> exactly 4 writes; ovf_clr -> overflow=0.
REQ-041 Reset asserted mid-line with 2 pixels packed -> outputs 0 at once; after release, pixels before the next vs falling edge produce no writes.
REQ-042 en=0 at vs falling edge -> whole frame produces no writes while frame_done still pulses; en=1 at the next vs edge -> capture resumes at FB_BASE.
